// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: holds the fetch PC, issues credit-limited word requests,
// buffers in-order responses and drives the IF/ID register with redirect/stall handling.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] branch_addr,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        if_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    cnt_t        out_q, out_d, disc_q, disc_d, fcnt_q, fcnt_d;
    ptr_t        aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
    ptr_t        f_wr_q, f_wr_d, f_rd_q, f_rd_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d;
    logic        vld_q, vld_d;

    logic [31:0] aq_mem [DEPTH];
    logic [63:0] f_mem  [DEPTH];

    logic        redirect, credit_ok, req_fire, resp_fire, resp_drop, resp_keep, pop;
    logic [CW:0] occupancy;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Credit covers both in-flight requests and buffered words, so the FIFO never overflows.
    assign occupancy      = {1'b0, out_q} + {1'b0, fcnt_q};
    assign credit_ok      = occupancy < (CW + 1)'(DEPTH);
    assign redirect       = br & ~stall;
    assign imem_req_valid = reset & credit_ok & ~redirect;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign resp_fire      = imem_resp_valid & (out_q != '0);
    assign resp_drop      = resp_fire & (disc_q != '0);
    assign resp_keep      = resp_fire & (disc_q == '0);
    assign pop            = ~redirect & ~stall & (fcnt_q != '0);

    assign pc       = pc_q;
    assign inst     = inst_q;
    assign if_valid = vld_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        disc_d     = disc_q;
        fcnt_d     = fcnt_q;
        aq_wr_d    = aq_wr_q;
        aq_rd_d    = aq_rd_q;
        f_wr_d     = f_wr_q;
        f_rd_d     = f_rd_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        vld_d      = vld_q;
        if (redirect) begin
            fetch_pc_d = branch_addr & 32'hFFFF_FFFC;
            // Every response still in flight after this edge belongs to the old path.
            out_d      = out_q - cnt_t'(resp_fire);
            disc_d     = out_q - cnt_t'(resp_fire);
            fcnt_d     = '0;
            aq_wr_d    = '0;
            aq_rd_d    = '0;
            f_wr_d     = '0;
            f_rd_d     = '0;
            pc_d       = '0;
            inst_d     = NOP_INST;
            vld_d      = 1'b0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                aq_wr_d    = ptr_inc(aq_wr_q);
            end
            out_d = out_q + cnt_t'(req_fire) - cnt_t'(resp_fire);
            if (resp_drop) begin
                disc_d = disc_q - cnt_t'(1);
            end
            if (resp_keep) begin
                aq_rd_d = ptr_inc(aq_rd_q);
                f_wr_d  = ptr_inc(f_wr_q);
            end
            if (pop) begin
                f_rd_d = ptr_inc(f_rd_q);
            end
            fcnt_d = fcnt_q + cnt_t'(resp_keep) - cnt_t'(pop);
            if (!stall) begin
                if (pop) begin
                    {pc_d, inst_d} = f_mem[f_rd_q];
                    vld_d          = 1'b1;
                end else begin
                    pc_d   = '0;
                    inst_d = NOP_INST;
                    vld_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
            fcnt_q     <= '0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
            f_wr_q     <= '0;
            f_rd_q     <= '0;
            pc_q       <= '0;
            inst_q     <= NOP_INST;
            vld_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            fcnt_q     <= fcnt_d;
            aq_wr_q    <= aq_wr_d;
            aq_rd_q    <= aq_rd_d;
            f_wr_q     <= f_wr_d;
            f_rd_q     <= f_rd_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            vld_q      <= vld_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and counts above.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            aq_mem[aq_wr_q] <= fetch_pc_q;
        end
        if (resp_keep && !redirect) begin
            f_mem[f_wr_q] <= {aq_mem[aq_rd_q], imem_resp_data};
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with an in-order instruction memory model whose
// word at address a is ~a.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        br;
    logic [31:0] branch_addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        if_valid;

    int checks   = 0;
    int failures = 0;

    int lat  = 1;
    logic spur = 1'b0;
    int cyc  = 0;

    typedef struct {
        logic [31:0] a;
        int          due;
    } req_t;
    req_t mq[$];

    if_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (4),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .stall          (stall),
        .br             (br),
        .branch_addr    (branch_addr),
        .pc             (pc),
        .inst           (inst),
        .if_valid       (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: accepts on the handshake, answers in order 'lat' edges later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            mq.delete();
        end else begin
            if (imem_resp_valid && !spur && mq.size() > 0) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end else if (spur) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
        end else if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~mq[0].a;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [3:0]  rdy_pat;
        int          nvalid;

        reset          = 1'b0;
        stall          = 1'b0;
        br             = 1'b0;
        branch_addr    = 32'h0;
        imem_req_ready = 1'b1;
        rdy_pat        = 4'b1001;
        nvalid         = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",        pc,                  32'h0);
        chk("rst_inst",      inst,                32'h13);
        chk("rst_valid",     32'(if_valid),       32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);

        // Startup: first instruction after the third edge.
        reset = 1'b1;
        step();
        chk("e1_addr",  imem_req_addr,  32'h4);
        chk("e1_valid", 32'(if_valid),  32'h0);
        step();
        chk("e2_valid", 32'(if_valid),  32'h0);
        step();
        chk("e3_valid", 32'(if_valid),  32'h1);
        chk("e3_pc",    pc,             32'h0);
        chk("e3_inst",  inst,           ~32'h0);
        step();
        chk("e4_pc",    pc,             32'h4);
        step();
        chk("e5_pc",    pc,             32'h8);
        chk("e5_inst",  inst,           ~32'h8);

        // Long stall: IF/ID frozen, credit runs out.
        stall = 1'b1;
        step();
        chk("stall_pc1",   pc,                  32'h8);
        step();
        chk("credit_full", 32'(imem_req_valid), 32'h0);
        repeat (3) step();
        chk("stall_pc5",    pc,                  32'h8);
        chk("stall_inst5",  inst,                ~32'h8);
        chk("stall_valid5", 32'(if_valid),       32'h1);
        chk("stall_req5",   32'(imem_req_valid), 32'h0);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_stall_pc", pc, 32'hC + 32'(4 * i));
        end

        // Redirect with two requests in flight.
        lat = 2;
        step();
        step();
        br          = 1'b1;
        branch_addr = 32'h0000_0102;
        lat         = 1;
        #1;
        chk("redir_withdraw", 32'(imem_req_valid), 32'h0);
        step();
        br = 1'b0;
        #1;
        chk("redir_bubble_v", 32'(if_valid),       32'h0);
        chk("redir_bubble_i", inst,                32'h13);
        chk("redir_bubble_p", pc,                  32'h0);
        chk("redir_addr",     imem_req_addr,       32'h100);
        chk("redir_reqv",     32'(imem_req_valid), 32'h1);
        step();
        chk("redir_r1_valid", 32'(if_valid), 32'h0);
        step();
        chk("redir_r2_valid", 32'(if_valid), 32'h0);
        step();
        chk("redir_tgt_pc",   pc,            32'h100);
        chk("redir_tgt_inst", inst,          ~32'h100);
        chk("redir_tgt_v",    32'(if_valid), 32'h1);
        step();
        chk("redir_next_pc",  pc,            32'h104);

        // Branch under stall is ignored; one cycle later it redirects.
        br          = 1'b1;
        stall       = 1'b1;
        branch_addr = 32'h0000_0200;
        #1;
        chk("brstall_reqv", 32'(imem_req_valid), 32'h1);
        step();
        chk("brstall_pc",    pc,            32'h104);
        chk("brstall_valid", 32'(if_valid), 32'h1);
        stall = 1'b0;
        step();
        chk("br2_bubble", 32'(if_valid), 32'h0);
        br = 1'b0;
        #1;
        chk("br2_addr", imem_req_addr, 32'h200);
        step();
        step();
        chk("br2_r2_valid", 32'(if_valid), 32'h0);
        step();
        chk("br2_tgt_pc",   pc,            32'h200);
        chk("br2_tgt_inst", inst,          ~32'h200);

        // Ready toggling and a slower memory: strict order and matching words.
        exp_pc = 32'h204;
        for (int i = 0; i < 30; i++) begin
            imem_req_ready = (i < 16) ? rdy_pat[i % 4] : 1'b1;
            lat            = 3;
            step();
            if (if_valid) begin
                chk("stream_pc",   pc,   exp_pc);
                chk("stream_inst", inst, ~exp_pc);
                exp_pc = exp_pc + 32'd4;
                nvalid++;
            end
        end
        chk("stream_count", 32'(nvalid >= 12), 32'h1);

        // Mid-stream reset, then a spurious response with nothing outstanding.
        imem_req_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("mrst_pc",    pc,                  32'h0);
        chk("mrst_inst",  inst,                32'h13);
        chk("mrst_valid", 32'(if_valid),       32'h0);
        chk("mrst_reqv",  32'(imem_req_valid), 32'h0);
        step();
        chk("mrst_hold_valid", 32'(if_valid), 32'h0);
        lat   = 1;
        reset = 1'b1;
        spur  = 1'b1;
        step();
        spur = 1'b0;
        chk("rel_e1_valid", 32'(if_valid), 32'h0);
        chk("rel_e1_addr",  imem_req_addr, 32'h4);
        step();
        chk("spur_ignored", 32'(if_valid), 32'h0);
        step();
        chk("rel_e3_pc",    pc,            32'h0);
        chk("rel_e3_inst",  inst,          ~32'h0);
        chk("rel_e3_valid", 32'(if_valid), 32'h1);
        step();
        chk("rel_e4_pc",    pc,            32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch front end; the producer of the `pc`/`inst` pair consumed by `ID_stage`.
- Consumes ID's back-channel: `StallCheck` arrives as `stall`; `br`/`branch_addr` arrive as the redirect.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words in a small FIFO and drives the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, max (outstanding requests + buffered words); range 2..8; full throughput needs DEPTH >= 3.
- NOP_INST, 32'h0000_0013, instruction driven on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address (bits [1:0] = 0).
- imem_resp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- stall  in  1  from ID StallCheck; hold the IF/ID register.
- br  in  1  redirect request from ID.
- branch_addr  in  32  redirect target; bits [1:0] ignored (treated as 0).
- pc  out  32  IF/ID register: PC of `inst`.
- inst  out  32  IF/ID register: instruction word.
- if_valid  out  1  IF/ID register holds a real instruction.

Behaviour:
- Reset values (asynchronous, while reset = 0):
  - fetch_pc = RESET_PC; outstanding = 0; discard = 0; FIFO empty.
  - pc = 0; inst = NOP_INST; if_valid = 0; imem_req_valid = 0.
- Redirect: `redirect = br & ~stall`. Stall has priority; `br` is ignored while stall = 1.
- Request channel:
  - imem_req_valid = (outstanding + fifo_count < DEPTH) & ~redirect; imem_req_addr = fetch_pc.
  - Handshake (valid & ready): fetch_pc += 4, wrapping modulo 2^32; outstanding += 1.
  - Request valid/addr stay stable until accepted, except when a redirect withdraws them.
- Response channel:
  - Each imem_resp_valid decrements outstanding.
  - If discard > 0: word dropped, discard -= 1.
  - Otherwise {address, data} pushed to the FIFO. The address comes from an internal in-order queue of issued addresses.
  - imem_resp_valid while outstanding == 0: ignored, no state change.
- IF/ID register update, each rising edge, in priority order:
  1. redirect: pc = 0, inst = NOP_INST, if_valid = 0; FIFO and address queue flushed; fetch_pc = {branch_addr[31:2], 2'b00}.
     - discard = outstanding after this edge (every in-flight response is dropped, including any arriving in the redirect cycle).
     - No request is issued in the redirect cycle.
  2. stall: pc, inst, if_valid held; the FIFO may still fill up to the credit limit.
  3. FIFO non-empty: pop head into pc/inst, if_valid = 1.
  4. FIFO empty: pc = 0, inst = NOP_INST, if_valid = 0.
- No bypass from response to IF/ID: a word arriving at edge N is visible in IF/ID after edge N+1.
- Latency (imem_req_ready = 1, 1-cycle response):
  - First instruction appears in IF/ID after the 3rd rising edge following reset release.
  - Steady state: 1 instruction per cycle when DEPTH >= 3.
  - After a redirect: the target instruction appears 3 edges after the redirect edge.
- Boundaries:
  - Credit limit prevents FIFO overflow; with DEPTH words held during a long stall, imem_req_valid = 0.
  - Push and pop in the same cycle are both allowed; fifo_count is unchanged.
  - Redirect while discard > 0: discard = the new outstanding count; responses are never double-counted.
  - Reset asserted mid-operation: everything clears at once. Memory responses belonging to pre-reset requests must not arrive after reset release; if they do, they are ignored because outstanding = 0.

Test Plan:
- Reset release, ready = 1, 1-cycle memory at 0x0,0x4,0x8 -> if_valid rises after edge 3 with pc = 0x0; pc = 0x4, 0x8 on the following edges, one per cycle.
- Stall held 5 cycles with the stream running -> pc/inst frozen; imem_req_valid falls once outstanding + fifo_count = 4; after stall release, pc continues with no skipped or duplicated address.
- br = 1, branch_addr = 0x0000_0102, stall = 0, with 2 requests outstanding -> next IF/ID is a bubble (inst = 0x13, if_valid = 0); both old responses are dropped; next request addr = 0x100; first valid pc = 0x100.
- br = 1 and stall = 1 in the same cycle -> no redirect, IF/ID held; br with stall = 0 one cycle later redirects normally.
- imem_req_ready toggling 1,0,0,1 and response latency 3 -> addresses issued in order, inst matches each address, no bubbles beyond those caused by memory wait.
- reset = 0 asserted mid-stream with 3 outstanding -> all outputs at reset values immediately; after release, fetch restarts at RESET_PC; spurious responses while outstanding = 0 are ignored.
